regbank32_8bit_wr: RTL and testbench
====================================

# regbank32_8bit_wr

Write side of the 32 x 8-bit register bank whose read side is the 32:1 8-bit read mux. Accepts single-byte writes over a valid/ready handshake, decodes the 5-bit address into one of 32 byte registers, and drives all 32 registers as a flat bus into the read mux. Includes a sequential bulk-clear engine that zeroes the bank one register per cycle. Sits between the datapath write-back stage and the read mux.

## Interface
Parameters:
- none; geometry is fixed at 32 entries x 8 bits.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_valid  in  1  write request present.
- wr_addr  in  5  target register index 0..31.
- wr_data  in  8  byte to write.
- wr_ready  out  1  combinational; bank can accept a write this cycle.
- wr_done  out  1  registered one-cycle pulse, one cycle after an accepted write.
- clr_req  in  1  request a bulk clear of all 32 registers.
- busy  out  1  high while the clear sequence runs.
- clr_done  out  1  registered one-cycle pulse when the clear completes.
- regs  out  256  flat register image; register n at bits [8n+7:8n]; feeds the read mux r0..r31 inputs.

## Operation
- States: IDLE, CLEAR. A 5-bit clear counter clr_idx is used in CLEAR.
- wr_ready = (state == IDLE) && !clr_req.
- Write accepted on a rising edge with wr_valid && wr_ready: register wr_addr <= wr_data. No other register changes. wr_done asserts for exactly the following cycle.
- Back-to-back writes: one per cycle at full rate. Writes to the same address on consecutive cycles: last write wins.
- wr_valid with wr_ready low: no effect, no wr_done; the requester holds wr_addr and wr_data stable until acceptance.
- IDLE -> CLEAR when clr_req is high in IDLE; clr_idx <= 0. clr_req has priority over a simultaneous wr_valid, and that write is not accepted.
- In CLEAR, each cycle: register clr_idx <= 8'h00 and clr_idx increments. When the edge clearing index 31 occurs: -> IDLE, clr_done pulses for the next cycle.
- A clear takes exactly 32 cycles in CLEAR. busy is high for all 32, and wr_ready is low for all 32.
- clr_req asserted during CLEAR is ignored and does not restart or extend the clear. clr_req still high on return to IDLE starts a new clear.
- wr_addr uses the full 5 bits; every value is valid, so there is no out-of-range case.

## Timing
- Reset, asynchronous and active-low:
  - all 32 registers go to 8'h00, so regs = 256'h0.
  - state = IDLE, clr_idx = 0.
  - wr_done = 0, clr_done = 0, busy = 0.
  - wr_ready = !clr_req.
- Reset during CLEAR aborts the sequence. No clr_done is issued.
- Write latency: the new value appears on regs immediately after the accepting edge. The read mux sees it in the next cycle.
- wr_done and clr_done are never high for more than one cycle per event.
- busy is a registered output, equal to (state == CLEAR).

## Configuration
- Macro: REGBANK_R0_ZERO_EN.
- Defined:
  - register 0 is hardwired to 8'h00, and regs[7:0] is constant 0.
  - writes to address 0 are handshaken normally (wr_ready, wr_done pulse) but the data is discarded.
  - no flop is implemented for register 0.
- Undefined: register 0 is an ordinary writable register.

## Test plan
- Reset, then write addr 5 data 8'hA5 -> wr_ready=1 at acceptance, regs[47:40]=8'hA5 after the edge, wr_done pulses one cycle, all other bytes 0.
- 32 back-to-back writes, addr n with data n+8'h40 -> one accepted per cycle, regs byte n = n+8'h40 for all n, 32 wr_done pulses.
- Bank filled, then clr_req for one cycle -> busy high exactly 32 cycles, wr_ready low throughout, regs=0 at end, single clr_done pulse.
- clr_req and wr_valid (addr 3, 8'h77) together in IDLE -> write rejected, no wr_done, clear runs, byte 3 = 0 at end. Writes during busy are also rejected.
- rst_n low at clear cycle 10 -> regs=0 immediately, state IDLE, no clr_done, wr_ready=1 after release.
- With REGBANK_R0_ZERO_EN: write addr 0 data 8'hFF -> wr_done pulses, regs[7:0] stays 8'h00. Without the macro: regs[7:0]=8'hFF.

Source files
------------

// File: rtl/regbank32_8bit_wr.sv
// Write side of the 32 x 8-bit register bank: handshaken byte writes plus a one-register-per-cycle bulk clear.
// Optional build macro REGBANK_R0_ZERO_EN hardwires register 0 to zero (no flop, writes discarded).
module regbank32_8bit_wr (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_valid,
    input  logic [4:0]   wr_addr,
    input  logic [7:0]   wr_data,
    output logic         wr_ready,
    output logic         wr_done,
    input  logic         clr_req,
    output logic         busy,
    output logic         clr_done,
    output logic [255:0] regs
);

    localparam int DATA_W = 8;
    localparam int DEPTH  = 32;

`ifdef REGBANK_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t           state, state_nxt;
    logic [4:0]       clr_idx, clr_idx_nxt;
    logic             wr_acc;
    logic             clr_last;
    logic [DEPTH-1:0] wr_hit;
    logic [DEPTH-1:0] clr_hit;

    // A pending clear request blocks writes in the same cycle.
    assign wr_ready = (state == IDLE) && !clr_req;
    assign wr_acc   = wr_valid && wr_ready;
    assign busy     = (state == CLEAR);
    assign clr_last = (state == CLEAR) && (clr_idx == 5'd31);

    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        if (state == IDLE) begin
            if (clr_req) begin
                state_nxt   = CLEAR;
                clr_idx_nxt = '0;
            end
        end else begin
            clr_idx_nxt = clr_idx + 5'd1;
            if (clr_idx == 5'd31) begin
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            clr_idx  <= '0;
            wr_done  <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            clr_idx  <= clr_idx_nxt;
            wr_done  <= wr_acc;
            clr_done <= clr_last;
        end
    end

    // One-hot enables; writes and clears never overlap because wr_ready is low in CLEAR.
    assign wr_hit  = wr_acc ? (DEPTH'(1) << wr_addr) : '0;
    assign clr_hit = (state == CLEAR) ? (DEPTH'(1) << clr_idx) : '0;

    for (genvar n = 0; n < DEPTH; n++) begin : g_reg
        if (n == 0 && R0_ZERO) begin : g_zero
            assign regs[DATA_W*n +: DATA_W] = '0;
        end else begin : g_flop
            logic [DATA_W-1:0] q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= '0;
                end else if (clr_hit[n]) begin
                    q <= '0;
                end else if (wr_hit[n]) begin
                    q <= wr_data;
                end
            end
            assign regs[DATA_W*n +: DATA_W] = q;
        end
    end

endmodule

// File: tb/tb_regbank32_8bit_wr.sv
// Directed bench for regbank32_8bit_wr: writes, back-to-back fill, bulk clear, collisions, reset abort, register 0.
module tb_regbank32_8bit_wr;

    logic         clk;
    logic         rst_n;
    logic         wr_valid;
    logic [4:0]   wr_addr;
    logic [7:0]   wr_data;
    logic         wr_ready;
    logic         wr_done;
    logic         clr_req;
    logic         busy;
    logic         clr_done;
    logic [255:0] regs;

    int n_vec;
    int n_err;
    logic [7:0] exp_bank [32];

    regbank32_8bit_wr dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .wr_done  (wr_done),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_done (clr_done),
        .regs     (regs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] pack_exp();
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < 32; i++) v[8*i +: 8] = exp_bank[i];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) exp_bank[i] = 8'h00;
    endtask

    // Single write, leaves wr_valid low after the accepting edge.
    task automatic do_write(input logic [4:0] a, input logic [7:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    initial begin
        int cnt;
        int ready_seen;
        int done_seen;
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        clr_req  = 1'b0;
        clear_model();

        // Reset state
        #12;
        check("rst_regs", regs, 256'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_wr_done", wr_done, 1'b0);
        check("rst_clr_done", clr_done, 1'b0);
        check("rst_wr_ready", wr_ready, 1'b1);
        clr_req = 1'b1;
        #1;
        check("rst_wr_ready_clr", wr_ready, 1'b0);
        clr_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Single write addr 5
        wr_valid = 1'b1;
        wr_addr  = 5'd5;
        wr_data  = 8'hA5;
        #1;
        check("w5_ready", wr_ready, 1'b1);
        tick();
        wr_valid = 1'b0;
        exp_bank[5] = 8'hA5;
        check("w5_regs", regs, pack_exp());
        check("w5_byte", regs[47:40], 8'hA5);
        check("w5_done", wr_done, 1'b1);
        tick();
        check("w5_done_drop", wr_done, 1'b0);

        // Same address on consecutive cycles: last write wins
        wr_valid = 1'b1;
        wr_addr  = 5'd7;
        wr_data  = 8'h12;
        tick();
        wr_data  = 8'h34;
        tick();
        wr_valid = 1'b0;
        exp_bank[7] = 8'h34;
        check("lww_regs", regs, pack_exp());

        // 32 back-to-back writes
        done_seen = 0;
        ready_seen = 0;
        for (int a = 0; a < 32; a++) begin
            wr_valid = 1'b1;
            wr_addr  = 5'(a);
            wr_data  = 8'(a) + 8'h40;
            #1;
            if (wr_ready) ready_seen++;
            tick();
            if (wr_done) done_seen++;
            exp_bank[a] = 8'(a) + 8'h40;
`ifdef REGBANK_R0_ZERO_EN
            exp_bank[0] = 8'h00;
`endif
        end
        wr_valid = 1'b0;
        check("fill_ready_cnt", 256'(ready_seen), 256'd32);
        check("fill_done_cnt", 256'(done_seen), 256'd32);
        check("fill_regs", regs, pack_exp());
        check("fill_byte31", regs[255:248], 8'h5F);
        tick();
        check("fill_done_drop", wr_done, 1'b0);

        // Bulk clear with writes attempted while busy
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        cnt = 0;
        ready_seen = 0;
        done_seen = 0;
        while (busy && cnt < 40) begin
            wr_valid = (cnt < 20);
            wr_addr  = 5'd9;
            wr_data  = 8'h99;
            #1;
            if (wr_ready) ready_seen++;
            if (wr_done || clr_done) done_seen++;
            cnt++;
            tick();
        end
        wr_valid = 1'b0;
        clear_model();
        check("clr_busy_cycles", 256'(cnt), 256'd32);
        check("clr_ready_low", 256'(ready_seen), 256'd0);
        check("clr_no_early_pulse", 256'(done_seen), 256'd0);
        check("clr_done_pulse", clr_done, 1'b1);
        check("clr_regs", regs, 256'h0);
        tick();
        check("clr_done_drop", clr_done, 1'b0);
        check("clr_idle_ready", wr_ready, 1'b1);

        // clr_req and wr_valid together: clear wins
        do_write(5'd3, 8'h11);
        exp_bank[3] = 8'h11;
        check("pre_col_regs", regs, pack_exp());
        clr_req  = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = 5'd3;
        wr_data  = 8'h77;
        #1;
        check("col_ready", wr_ready, 1'b0);
        tick();
        clr_req  = 1'b0;
        wr_valid = 1'b0;
        check("col_no_done", wr_done, 1'b0);
        check("col_busy", busy, 1'b1);
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            tick();
        end
        clear_model();
        check("col_cycles", 256'(cnt), 256'd32);
        check("col_byte3", regs[31:24], 8'h00);
        check("col_regs", regs, 256'h0);

        // Reset during clear cycle 10
        do_write(5'd20, 8'hC3);
        do_write(5'd25, 8'h5A);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("abort_busy_pre", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_regs", regs, 256'h0);
        check("abort_busy", busy, 1'b0);
        check("abort_clr_done", clr_done, 1'b0);
        tick();
        rst_n = 1'b1;
        #1;
        check("abort_ready", wr_ready, 1'b1);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (clr_done || busy) done_seen++;
            tick();
        end
        check("abort_no_clr_done", 256'(done_seen), 256'd0);

        // Register 0 write
        clear_model();
        do_write(5'd0, 8'hFF);
        check("r0_done", wr_done, 1'b1);
`ifdef REGBANK_R0_ZERO_EN
        check("r0_byte", regs[7:0], 8'h00);
`else
        check("r0_byte", regs[7:0], 8'hFF);
`endif
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
